// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths:
// FSM state encoding, data width and idle line level.
package uart_pkg;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// o_bit_strobe in the last clock of every bit period.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_bit_strobe
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;
  logic          w_terminal;

  assign w_terminal   = (r_count == TERMINAL);
  assign o_bit_strobe = i_enable && w_terminal;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_terminal ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/tx_block.sv
// UART transmitter (8 data bits, no parity, 1 or 2 stop bits) with a
// one-entry holding buffer so back-to-back frames leave no idle gap.
module tx_block
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       load_data,
  input  logic       clear_error,
  output logic       serial_out,
  output logic       buffer_empty,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       overrun_error
);
  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP_BIT = 1'(STOP_BITS - 1);

  tx_state_t  r_state;
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;
  logic       r_serial_out;
  logic       r_overrun;

  logic w_strobe;
  logic w_stop_last;
  logic w_transfer;
  logic w_accept;
  logic w_overrun;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (r_state != IDLE),
    .i_clear     (r_state == IDLE),
    .o_bit_strobe(w_strobe)
  );

  // The buffer empties into the shift register either from IDLE or in the very
  // last cycle of the final stop bit, which is what makes frames back-to-back.
  assign w_stop_last = (r_state == STOP) && w_strobe && (r_stop_cnt == LAST_STOP_BIT);
  assign w_transfer  = r_buf_full && ((r_state == IDLE) || w_stop_last);
  assign w_accept    = load_data && (!r_buf_full || w_transfer);
  assign w_overrun   = load_data && r_buf_full && !w_transfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end else if (w_transfer) begin
        r_buf_full <= 1'b0;
      end
      if (w_overrun) begin
        r_overrun <= 1'b1;
      end else if (clear_error) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_serial_out <= IDLE_LEVEL;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_transfer) begin
            r_state      <= START;
            r_shift      <= r_buf;
            r_serial_out <= 1'b0;
          end
        end
        START: begin
          if (w_strobe) begin
            r_state      <= DATA;
            r_bit_cnt    <= '0;
            r_serial_out <= r_shift[0];
          end
        end
        DATA: begin
          if (w_strobe) begin
            if (r_bit_cnt == LAST_DATA_BIT) begin
              r_state      <= STOP;
              r_stop_cnt   <= 1'b0;
              r_serial_out <= IDLE_LEVEL;
            end else begin
              r_bit_cnt    <= r_bit_cnt + 1'b1;
              r_shift      <= r_shift >> 1;
              r_serial_out <= r_shift[1];
            end
          end
        end
        STOP: begin
          if (w_stop_last) begin
            if (w_transfer) begin
              r_state      <= START;
              r_shift      <= r_buf;
              r_serial_out <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_strobe) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign serial_out    = r_serial_out;
  assign buffer_empty  = !r_buf_full;
  assign tx_busy       = (r_state != IDLE);
  assign tx_done       = w_stop_last;
  assign overrun_error = r_overrun;
endmodule

// File: tb/tb_tx_block.sv
// Self-checking bench for tx_block: per-cycle comparison against a frame-level
// reference model, a directed vector table, multi-cycle sequences and random traffic.
module tb_tx_block;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] ld;
  logic [1:0] clr;
  logic [7:0] dat [2];
  logic [1:0] so, be, bz, dn, ov;

  tx_block #(.CLKS_PER_BIT(10), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .tx_data(dat[0]), .load_data(ld[0]), .clear_error(clr[0]),
    .serial_out(so[0]), .buffer_empty(be[0]), .tx_busy(bz[0]), .tx_done(dn[0]),
    .overrun_error(ov[0])
  );

  tx_block #(.CLKS_PER_BIT(16), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(dat[1]), .load_data(ld[1]), .clear_error(clr[1]),
    .serial_out(so[1]), .buffer_empty(be[1]), .tx_busy(bz[1]), .tx_done(dn[1]),
    .overrun_error(ov[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: a frame is a list of line levels indexed by cycle position.
  int         m_cpb [2] = '{10, 16};
  int         m_sb  [2] = '{1, 2};
  bit         m_full[2];
  bit         m_ov  [2];
  logic [7:0] m_buf [2];
  logic [7:0] m_frame[2];
  int         m_rem [2];
  bit e_so[2], e_be[2], e_bz[2], e_dn[2], e_ov[2];

  int done_cnt[2];
  int done_at [2];

  int w_fall, w_done, w_busy;
  bit hist[400];

  typedef struct {
    logic [7:0] a, b, c;
    int gb, gc;
    bit exp_ovr;
    int exp_frames;
    int exp_done_gap;
  } vec_t;
  vec_t vecs[5];

  function automatic bit frame_level(logic [7:0] d, int pos, int cpb);
    int bp;
    bp = pos / cpb;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return d[bp-1];
    return 1'b1;
  endfunction

  task automatic model_step(int u);
    int  fl;
    bit  full_old, xfer;
    fl = (9 + m_sb[u]) * m_cpb[u];
    if (rst[u]) begin
      m_full[u] = 0; m_ov[u] = 0; m_rem[u] = 0;
    end else begin
      full_old = m_full[u];
      xfer = full_old && (m_rem[u] == 0);
      if (xfer) begin
        m_frame[u] = m_buf[u]; m_rem[u] = fl; m_full[u] = 0;
      end
      if (ld[u] && (!full_old || xfer)) begin
        m_buf[u] = dat[u]; m_full[u] = 1;
      end
      if (ld[u] && full_old && !xfer) m_ov[u] = 1;
      else if (clr[u]) m_ov[u] = 0;
    end
    if (m_rem[u] > 0) begin
      e_so[u] = frame_level(m_frame[u], fl - m_rem[u], m_cpb[u]);
      e_bz[u] = 1; e_dn[u] = (m_rem[u] == 1);
      m_rem[u]--;
    end else begin
      e_so[u] = 1; e_bz[u] = 0; e_dn[u] = 0;
    end
    e_be[u] = !m_full[u];
    e_ov[u] = m_ov[u];
  endtask

  task automatic chk(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  task automatic check_model(int u);
    tests++;
    if (so[u] !== e_so[u] || be[u] !== e_be[u] || bz[u] !== e_bz[u] ||
        dn[u] !== e_dn[u] || ov[u] !== e_ov[u]) begin
      fails++;
      $display("FAIL model_u%0d cycle %0d: got so=%b empty=%b busy=%b done=%b ovr=%b, want so=%b empty=%b busy=%b done=%b ovr=%b",
               u, cyc, so[u], be[u], bz[u], dn[u], ov[u],
               e_so[u], e_be[u], e_bz[u], e_dn[u], e_ov[u]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
    check_model(0);
    check_model(1);
    for (int u = 0; u < 2; u++) begin
      if (dn[u] === 1'b1) begin
        done_cnt[u]++;
        done_at[u] = cyc;
      end
    end
    ld = '0; clr = '0; rst = '0;
  endtask

  task automatic load(int u, logic [7:0] d);
    ld[u] = 1'b1;
    dat[u] = d;
    $display("[TB] u%0d load 0x%02h at cycle %0d", u, d, cyc);
  endtask

  task automatic watch(int u, int bound);
    w_fall = -1; w_done = -1; w_busy = 0;
    for (int n = 0; n < bound; n++) begin
      cycle();
      if (w_fall < 0 && so[u] === 1'b0) w_fall = cyc;
      if (w_fall >= 0 && cyc - w_fall < 400) hist[cyc - w_fall] = so[u];
      if (bz[u] === 1'b1) w_busy++;
      if (dn[u] === 1'b1) begin
        w_done = cyc;
        break;
      end
    end
  endtask

  task automatic run_idle(int u, int bound);
    int n;
    n = 0;
    while ((bz[u] !== 1'b0 || be[u] !== 1'b1) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_in_time", (n < bound) ? 1 : 0, 1);
  endtask

  initial begin
    int t0, d0, k, fr0, gapk, rbyte;
    logic [7:0] ref_byte;
    rst = 2'b11; ld = '0; clr = '0;
    dat[0] = '0; dat[1] = '0;
    done_cnt = '{0, 0}; done_at = '{0, 0};

    vecs[0] = '{a: 8'hA5, b: 8'h00, c: 8'h00, gb: -1, gc: -1, exp_ovr: 0, exp_frames: 1, exp_done_gap: 0};
    vecs[1] = '{a: 8'h00, b: 8'hFF, c: 8'h00, gb: 50, gc: -1, exp_ovr: 0, exp_frames: 2, exp_done_gap: 100};
    vecs[2] = '{a: 8'h11, b: 8'h22, c: 8'h33, gb: 1,  gc: 2,  exp_ovr: 1, exp_frames: 2, exp_done_gap: 100};
    vecs[3] = '{a: 8'h3C, b: 8'hC3, c: 8'h00, gb: 1,  gc: -1, exp_ovr: 0, exp_frames: 2, exp_done_gap: 100};
    vecs[4] = '{a: 8'h55, b: 8'hAA, c: 8'h0F, gb: 5,  gc: 150, exp_ovr: 0, exp_frames: 3, exp_done_gap: 100};

    cycle();
    rst = 2'b11;
    cycle();
    chk("reset_serial_out", so[0], 1);
    chk("reset_buffer_empty", be[0], 1);
    chk("reset_busy", bz[0], 0);
    chk("reset_done", dn[0], 0);
    chk("reset_overrun", ov[0], 0);

    // Single frame 0xA5 with absolute timing
    t0 = cyc;
    ref_byte = 8'hA5;
    load(0, ref_byte);
    watch(0, 300);
    chk("a5_start_fall", w_fall, t0 + 2);
    chk("a5_done_cycle", w_done, t0 + 101);
    chk("a5_busy_cycles", w_busy, 100);
    for (int i = 0; i < 8; i++) chk("a5_bit", hist[15 + 10 * i], ref_byte[i]);
    chk("a5_stop", hist[99], 1);
    run_idle(0, 50);

    // Vector table
    foreach (vecs[r]) begin
      fr0 = done_cnt[0];
      gapk = (vecs[r].gc > vecs[r].gb) ? vecs[r].gc : vecs[r].gb;
      if (gapk < 0) gapk = 0;
      for (k = 0; k <= gapk; k++) begin
        if (k == 0) load(0, vecs[r].a);
        if (k == vecs[r].gb) load(0, vecs[r].b);
        if (k == vecs[r].gc) load(0, vecs[r].c);
        d0 = done_at[0];
        cycle();
        if (vecs[r].exp_done_gap != 0 && done_at[0] != d0 && done_cnt[0] - fr0 == 2)
          chk("b2b_done_gap", done_at[0] - d0, vecs[r].exp_done_gap);
      end
      for (k = 0; k < 1000 && (bz[0] !== 1'b0 || be[0] !== 1'b1); k++) begin
        d0 = done_at[0];
        cycle();
        if (vecs[r].exp_done_gap != 0 && done_at[0] != d0 && done_cnt[0] - fr0 == 2)
          chk("b2b_done_gap", done_at[0] - d0, vecs[r].exp_done_gap);
      end
      chk("vec_drain", (k < 1000) ? 1 : 0, 1);
      chk("vec_frames", done_cnt[0] - fr0, vecs[r].exp_frames);
      chk("vec_overrun", ov[0], vecs[r].exp_ovr);
      clr[0] = 1'b1;
      cycle();
      chk("vec_overrun_cleared", ov[0], 0);
      $display("[TB] vector %0d done: frames=%0d", r, done_cnt[0] - fr0);
    end

    // Mid-frame reset aborts the frame
    t0 = cyc;
    load(0, 8'h3C);
    while (cyc < t0 + 42) cycle();
    fr0 = done_cnt[0];
    rst[0] = 1'b1;
    cycle();
    chk("rst_mid_serial_out", so[0], 1);
    chk("rst_mid_buffer_empty", be[0], 1);
    chk("rst_mid_busy", bz[0], 0);
    for (int i = 0; i < 150; i++) cycle();
    chk("rst_mid_no_done", done_cnt[0] - fr0, 0);
    t0 = cyc;
    load(0, 8'h3C);
    watch(0, 300);
    chk("rst_reload_fall", w_fall, t0 + 2);
    chk("rst_reload_frame_len", w_done - w_fall + 1, 100);
    rbyte = 0;
    for (int i = 0; i < 8; i++) rbyte |= int'(hist[15 + 10 * i]) << i;
    chk("rst_reload_byte", rbyte, 8'h3C);

    // 16 clocks per bit, two stop bits
    t0 = cyc;
    load(1, 8'h80);
    watch(1, 400);
    chk("cpb16_start_fall", w_fall, t0 + 2);
    chk("cpb16_frame_len", w_done - w_fall + 1, 176);
    chk("cpb16_busy", w_busy, 176);
    chk("cpb16_bit6_end", hist[127], 0);
    chk("cpb16_bit7_first", hist[128], 1);
    chk("cpb16_bit7_last", hist[143], 1);
    chk("cpb16_stop_first", hist[144], 1);
    chk("cpb16_stop_last", hist[175], 1);
    run_idle(1, 50);

    // Random traffic on both instances, checked cycle by cycle against the model
    for (int n = 0; n < 6000; n++) begin
      for (int u = 0; u < 2; u++) begin
        if ($urandom_range(0, 39) == 0) load(u, 8'($urandom));
        if ($urandom_range(0, 59) == 0) clr[u] = 1'b1;
        if ($urandom_range(0, 999) == 0) rst[u] = 1'b1;
      end
      cycle();
    end
    run_idle(0, 1000);
    run_idle(1, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
